// File: rtl/axi_noc_pkg.sv
// Shared definitions for the AXI write-path arbiter: parameter defaults, FSM state
// encoding and the 1-bit master index used for grants and B routing.
package axi_noc_pkg;

   localparam int AXI_ID_WIDTH_DEF    = 4;
   localparam int AXI_ADDR_WIDTH_DEF  = 32;
   localparam int AXI_DATA_WIDTH_DEF  = 64;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef enum logic {
      ARB  = 1'b0,
      DATA = 1'b1
   } state_t;

   typedef logic mst_idx_t;

endpackage

// File: rtl/axi_route_fifo.sv
// Synchronous FIFO of master indices; remembers which master owns each outstanding
// write so B responses are returned in AW order. DEPTH must be a power of two.
module axi_route_fifo
   import axi_noc_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  mst_idx_t din,
   input  logic     pop,
   output mst_idx_t dout,
   output logic     full,
   output logic     empty
);

   localparam int PW = $clog2(DEPTH);

   mst_idx_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Two-master to one-slave AXI write arbiter: round-robin AW grant, W burst forwarding
// and in-order B routing. Optional W beat-count check enabled by AXI_WR_ARB_LEN_CHECK_EN.
module axi_wr_rr_arbiter
   import axi_noc_pkg::*;
#(
   parameter int AXI_ID_WIDTH    = AXI_ID_WIDTH_DEF,
   parameter int AXI_ADDR_WIDTH  = AXI_ADDR_WIDTH_DEF,
   parameter int AXI_DATA_WIDTH  = AXI_DATA_WIDTH_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   // master-side AW
   input  logic [1:0][AXI_ID_WIDTH-1:0]        m_awid,
   input  logic [1:0][AXI_ADDR_WIDTH-1:0]      m_awaddr,
   input  logic [1:0][7:0]                     m_awlen,
   input  logic [1:0]                          m_awvalid,
   output logic [1:0]                          m_awready,
   // master-side W
   input  logic [1:0][AXI_DATA_WIDTH-1:0]      m_wdata,
   input  logic [1:0]                          m_wlast,
   input  logic [1:0]                          m_wvalid,
   output logic [1:0]                          m_wready,
   // master-side B
   output logic [1:0][AXI_ID_WIDTH-1:0]        m_bid,
   output logic [1:0][1:0]                     m_bresp,
   output logic [1:0]                          m_bvalid,
   input  logic [1:0]                          m_bready,
   // slave-side AW
   output logic [AXI_ID_WIDTH-1:0]             s_awid,
   output logic [AXI_ADDR_WIDTH-1:0]           s_awaddr,
   output logic [7:0]                          s_awlen,
   output logic                                s_awvalid,
   input  logic                                s_awready,
   // slave-side W
   output logic [AXI_DATA_WIDTH-1:0]           s_wdata,
   output logic                                s_wlast,
   output logic                                s_wvalid,
   input  logic                                s_wready,
   // slave-side B
   input  logic [AXI_ID_WIDTH-1:0]             s_bid,
   input  logic [1:0]                          s_bresp,
   input  logic                                s_bvalid,
   output logic                                s_bready,
   output logic                                len_err,
   output state_t                              state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and a stalled AW keeps its grant and payload.
   state_t   state, state_nxt;
   mst_idx_t rr_last;
   mst_idx_t grant;
   mst_idx_t w_owner;
   logic     aw_lock;
   mst_idx_t lock_g;
   mst_idx_t b_head;
   logic     fifo_full, fifo_empty;
   logic     aw_hs, w_hs, b_hs;

   assign state_dbg = state;

   always_comb begin
      grant = 1'b0;
      if (aw_lock)                grant = lock_g;
      else if (m_awvalid == 2'b11) grant = ~rr_last;
      else if (m_awvalid[1])      grant = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      s_awid    = m_awid[grant];
      s_awaddr  = m_awaddr[grant];
      s_awlen   = m_awlen[grant];
      s_awvalid = 1'b0;
      m_awready = 2'b00;
      s_wdata   = m_wdata[w_owner];
      s_wlast   = m_wlast[w_owner];
      s_wvalid  = 1'b0;
      m_wready  = 2'b00;
      if (!rst) begin
         case (state)
            ARB: begin
               // Route FIFO full blocks AW even if a B pop happens this cycle.
               s_awvalid        = m_awvalid[grant] && !fifo_full;
               m_awready[grant] = s_awready && !fifo_full;
               if (s_awvalid && s_awready) state_nxt = DATA;
            end
            DATA: begin
               s_wvalid          = m_wvalid[w_owner];
               m_wready[w_owner] = s_wready;
               if (s_wvalid && s_wready && s_wlast) state_nxt = ARB;
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ARB;
         rr_last <= 1'b1;
         w_owner <= 1'b0;
         aw_lock <= 1'b0;
         lock_g  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (aw_hs) begin
            w_owner <= grant;
            rr_last <= grant;
            aw_lock <= 1'b0;
         end else if (s_awvalid) begin
            aw_lock <= 1'b1;
            lock_g  <= grant;
         end
      end
   end

   axi_route_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_route_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (aw_hs),
      .din   (grant),
      .pop   (b_hs),
      .dout  (b_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // B goes to whichever master issued the oldest outstanding AW.
   always_comb begin
      m_bid    = {2{s_bid}};
      m_bresp  = {2{s_bresp}};
      m_bvalid = 2'b00;
      s_bready = 1'b0;
      if (!rst && !fifo_empty) begin
         m_bvalid[b_head] = s_bvalid;
         s_bready         = m_bready[b_head];
      end
   end

   assign b_hs = s_bvalid && s_bready;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
   logic [7:0] beat_cnt;

   // Counter holds beats still expected after the current one; wlast must land on zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= 8'd0;
         len_err  <= 1'b0;
      end else if (aw_hs) begin
         beat_cnt <= s_awlen;
      end else if (w_hs) begin
         if (s_wlast != (beat_cnt == 8'd0)) len_err <= 1'b1;
         if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
      end
   end
`else
   assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Randomized bench for axi_wr_rr_arbiter: master/slave drivers, a negedge monitor with
// a transaction-level model (pending AW queues, B route order), and a final report.
module tb_axi_wr_rr_arbiter;
   import axi_noc_pkg::*;

   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int MO  = 4;

   typedef struct {
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [7:0]     len;
   } aw_t;

   typedef struct {
      aw_t aw;
      int  nbeats;
   } txn_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      int             m;
      logic [IDW-1:0] id;
   } route_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [1:0][IDW-1:0]   m_awid;
   logic [1:0][AW-1:0]    m_awaddr;
   logic [1:0][7:0]       m_awlen;
   logic [1:0]            m_awvalid;
   logic [1:0]            m_awready;
   logic [1:0][DW-1:0]    m_wdata;
   logic [1:0]            m_wlast;
   logic [1:0]            m_wvalid;
   logic [1:0]            m_wready;
   logic [1:0][IDW-1:0]   m_bid;
   logic [1:0][1:0]       m_bresp;
   logic [1:0]            m_bvalid;
   logic [1:0]            m_bready;
   logic [IDW-1:0]        s_awid;
   logic [AW-1:0]         s_awaddr;
   logic [7:0]            s_awlen;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [DW-1:0]         s_wdata;
   logic                  s_wlast;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [IDW-1:0]        s_bid;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic                  len_err;
   state_t                state_dbg;

   axi_wr_rr_arbiter #(
      .AXI_ID_WIDTH    (IDW),
      .AXI_ADDR_WIDTH  (AW),
      .AXI_DATA_WIDTH  (DW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_awid    (m_awid),
      .m_awaddr  (m_awaddr),
      .m_awlen   (m_awlen),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_wdata   (m_wdata),
      .m_wlast   (m_wlast),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_bid     (m_bid),
      .m_bresp   (m_bresp),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready),
      .s_awid    (s_awid),
      .s_awaddr  (s_awaddr),
      .s_awlen   (s_awlen),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wlast   (s_wlast),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bid     (s_bid),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .len_err   (len_err),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // stimulus queues and expected queues (scoreboard)
   txn_t   txq [2][$];
   aw_t    exp_aw_q [2][$];
   beat_t  exp_w_q [2][$];
   beat_t  drv_w_q [2][$];
   route_t rq [$];
   logic [IDW-1:0] sq [$];

   // handshake notifications from monitor to drivers
   bit             aw_hs_f, w_hs_f, b_hs_f;
   int             aw_hs_g, w_hs_m;
   logic [IDW-1:0] aw_hs_id;

   // logs for directed checks
   int             grant_log [$];
   int             b_log_m [$];
   logic [IDW-1:0] b_log_id [$];
   int             aw_done = 0;
   int             w_total = 0;

   // reference model state
   bit   in_data   = 1'b0;
   int   owner     = 0;
   int   last_win  = 1;
   bit   frozen    = 1'b0;
   int   frozen_g  = 0;
   int   len_cur   = 0;
   int   bcount    = 0;
   bit   exp_len_err = 1'b0;

   // driver state
   bit         b_en   = 1'b0;
   bit         junk_b = 1'b0;
   bit         rst_seen = 1'b0;
   bit [1:0]   aw_act = 2'b00;
   bit [1:0]   w_go   = 2'b00;
   bit         bv     = 1'b0;
   logic [1:0] drv_bresp = 2'b00;

   // ---------------- driver tasks ----------------
   task automatic issue(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input int nbeats);
      txn_t t;
      t.aw.id   = id;
      t.aw.addr = addr;
      t.aw.len  = len;
      t.nbeats  = nbeats;
      txq[m].push_back(t);
   endtask

   task automatic clear_all();
      aw_act = 2'b00;
      w_go   = 2'b00;
      bv     = 1'b0;
      for (int m = 0; m < 2; m++) drv_w_q[m].delete();
      sq.delete();
      m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awvalid = '0;
      m_wdata = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
      s_awready = 1'b0; s_wready = 1'b0;
      s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
   endtask

   task automatic drive_tick();
      txn_t  t;
      beat_t b;
      if (rst) begin
         // first reset cycle keeps inputs active so output gating is exercised
         if (rst_seen) clear_all();
         rst_seen = 1'b1;
         return;
      end
      rst_seen = 1'b0;
      if (b_hs_f) begin
         if (sq.size() > 0) void'(sq.pop_front());
         bv = 1'b0;
      end
      if (aw_hs_f) sq.push_back(aw_hs_id);
      for (int m = 0; m < 2; m++) begin
         if (aw_hs_f && aw_hs_g == m) begin
            aw_act[m]    = 1'b0;
            m_awvalid[m] = 1'b0;
            w_go[m]      = 1'b1;
         end
         if (w_hs_f && w_hs_m == m && drv_w_q[m].size() > 0) void'(drv_w_q[m].pop_front());
         if (w_go[m] && drv_w_q[m].size() == 0) w_go[m] = 1'b0;
         if (!aw_act[m] && !w_go[m] && txq[m].size() > 0) begin
            t = txq[m].pop_front();
            m_awid[m]    = t.aw.id;
            m_awaddr[m]  = t.aw.addr;
            m_awlen[m]   = t.aw.len;
            m_awvalid[m] = 1'b1;
            aw_act[m]    = 1'b1;
            exp_aw_q[m].push_back(t.aw);
            for (int k = 0; k < t.nbeats; k++) begin
               b.data = {$urandom(), $urandom()};
               b.last = (k == t.nbeats - 1);
               drv_w_q[m].push_back(b);
               exp_w_q[m].push_back(b);
            end
         end
         if (w_go[m]) begin
            m_wvalid[m] = 1'b1;
            m_wdata[m]  = drv_w_q[m][0].data;
            m_wlast[m]  = drv_w_q[m][0].last;
         end else begin
            m_wvalid[m] = 1'($urandom_range(0, 1));
            m_wdata[m]  = {$urandom(), $urandom()};
            m_wlast[m]  = 1'($urandom_range(0, 1));
         end
      end
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready  = ($urandom_range(0, 2) != 0);
      if (junk_b) begin
         s_bvalid = 1'b1;
         s_bid    = 4'hf;
         s_bresp  = 2'b10;
      end else begin
         if (!bv && b_en && sq.size() > 0 && $urandom_range(0, 1) == 1) begin
            bv        = 1'b1;
            s_bid     = sq[0];
            drv_bresp = 2'($urandom_range(0, 3));
            s_bresp   = drv_bresp;
         end
         s_bvalid = bv;
      end
      m_bready = 2'($urandom_range(0, 3));
   endtask

   initial begin
      clear_all();
      forever begin
         @(posedge clk);
         #1;
         drive_tick();
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      bit     cur_data;
      int     occ;
      int     g;
      int     cnt;
      aw_t    a;
      beat_t  b;
      route_t h;
      bit     exp_awv;
      aw_hs_f = 1'b0;
      w_hs_f  = 1'b0;
      b_hs_f  = 1'b0;
      if (rst) begin
         chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
         chk("rst_m_awready", 64'(m_awready), 64'd0);
         chk("rst_s_wvalid",  64'(s_wvalid),  64'd0);
         chk("rst_m_wready",  64'(m_wready),  64'd0);
         chk("rst_m_bvalid",  64'(m_bvalid),  64'd0);
         chk("rst_s_bready",  64'(s_bready),  64'd0);
         chk("rst_len_err",   64'(len_err),   64'd0);
         chk("rst_state",     64'(state_dbg == DATA), 64'd0);
         in_data = 1'b0; last_win = 1; frozen = 1'b0; exp_len_err = 1'b0;
         rq.delete();
         for (int m = 0; m < 2; m++) begin
            exp_aw_q[m].delete();
            exp_w_q[m].delete();
         end
      end else begin
         cur_data = in_data;
         occ      = rq.size();
         chk("len_err", 64'(len_err), 64'(exp_len_err));
         chk("state",   64'(state_dbg == DATA), 64'(cur_data));
         // B routing: oldest outstanding AW owns the response
         if (occ == 0) begin
            chk("b_empty_s_bready", 64'(s_bready), 64'd0);
            chk("b_empty_m_bvalid", 64'(m_bvalid), 64'd0);
         end else begin
            h = rq[0];
            chk("m_bvalid", 64'(m_bvalid), bv ? 64'(2'b01 << h.m) : 64'd0);
            chk("s_bready", 64'(s_bready), 64'(m_bready[h.m]));
            if (bv) begin
               chk("m_bid",   64'(m_bid[h.m]),   64'(h.id));
               chk("m_bresp", 64'(m_bresp[h.m]), 64'(drv_bresp));
            end
            if (s_bvalid && s_bready) begin
               void'(rq.pop_front());
               b_log_m.push_back(h.m);
               b_log_id.push_back(m_bid[h.m]);
               b_hs_f = 1'b1;
            end
         end
         // AW: round robin over pending requests, grant held while stalled
         exp_awv = !cur_data && (m_awvalid != 2'b00) && (occ < MO);
         chk("s_awvalid", 64'(s_awvalid), 64'(exp_awv));
         if (exp_awv && s_awvalid) begin
            if (frozen)                    g = frozen_g;
            else if (m_awvalid == 2'b11)   g = 1 - last_win;
            else if (m_awvalid[1])         g = 1;
            else                           g = 0;
            chk("m_awready", 64'(m_awready), s_awready ? 64'(2'b01 << g) : 64'd0);
            if (exp_aw_q[g].size() == 0) begin
               chk("aw_unexpected", 64'd1, 64'd0);
            end else begin
               a = exp_aw_q[g][0];
               chk("s_awid",   64'(s_awid),   64'(a.id));
               chk("s_awaddr", 64'(s_awaddr), 64'(a.addr));
               chk("s_awlen",  64'(s_awlen),  64'(a.len));
               if (s_awready) begin
                  void'(exp_aw_q[g].pop_front());
                  rq.push_back('{m: g, id: a.id});
                  last_win = g; frozen = 1'b0; in_data = 1'b1; owner = g;
                  len_cur = int'(a.len); bcount = 0;
                  aw_hs_f = 1'b1; aw_hs_g = g; aw_hs_id = a.id;
                  grant_log.push_back(g);
                  aw_done++;
               end else begin
                  frozen = 1'b1; frozen_g = g;
               end
            end
         end else if (cur_data || occ >= MO) begin
            chk("m_awready_blocked", 64'(m_awready), 64'd0);
         end
         // W: only the owner's beats reach the slave
         if (cur_data) begin
            chk("s_wvalid", 64'(s_wvalid), 64'(m_wvalid[owner]));
            chk("m_wready", 64'(m_wready), s_wready ? 64'(2'b01 << owner) : 64'd0);
            if (s_wvalid && s_wready) begin
               if (exp_w_q[owner].size() == 0) begin
                  chk("w_unexpected", 64'd1, 64'd0);
               end else begin
                  b = exp_w_q[owner].pop_front();
                  chk("s_wdata", s_wdata, b.data);
                  chk("s_wlast", 64'(s_wlast), 64'(b.last));
                  cnt = (bcount >= len_cur) ? 0 : len_cur - bcount;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
                  if (b.last ? (cnt != 0) : (cnt == 0)) exp_len_err = 1'b1;
`endif
                  bcount++;
                  if (b.last) in_data = 1'b0;
               end
               w_hs_f = 1'b1; w_hs_m = owner;
               w_total++;
            end
         end else begin
            chk("arb_s_wvalid", 64'(s_wvalid), 64'd0);
            chk("arb_m_wready", 64'(m_wready), 64'd0);
         end
      end
   end

   // ---------------- sequencing ----------------
   task automatic wait_idle(input int budget, input string tag);
      for (int c = 0; c < budget; c++) begin
         if (txq[0].size() == 0 && txq[1].size() == 0 &&
             exp_aw_q[0].size() == 0 && exp_aw_q[1].size() == 0 &&
             exp_w_q[0].size() == 0 && exp_w_q[1].size() == 0 &&
             rq.size() == 0 && !in_data)
            return;
         @(posedge clk);
      end
      chk({"idle_timeout_", tag}, 64'd1, 64'd0);
   endtask

   task automatic issue_random(input int n);
      int len;
      for (int i = 0; i < n; i++) begin
         len = $urandom_range(0, 7);
         issue($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom(), 8'(len), len + 1);
      end
   endtask

   initial begin
      int gb, bb, ab, wb, cyc;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      b_en = 1'b1;

      // simultaneous requests after reset: master 0 then master 1, B in AW order
      gb = grant_log.size();
      bb = b_log_m.size();
      issue(0, 4'd2, 32'h0000_1000, 8'd1, 2);
      issue(1, 4'd5, 32'h0000_2000, 8'd2, 3);
      wait_idle(500, "tie");
      if (grant_log.size() >= gb + 2) begin
         chk("tie_first_grant",  64'(grant_log[gb]),     64'd0);
         chk("tie_second_grant", 64'(grant_log[gb + 1]), 64'd1);
      end else chk("tie_grant_count", 64'(grant_log.size() - gb), 64'd2);
      if (b_log_m.size() >= bb + 2) begin
         chk("b_order_m0",  64'(b_log_m[bb]),      64'd0);
         chk("b_order_id0", 64'(b_log_id[bb]),     64'd2);
         chk("b_order_m1",  64'(b_log_m[bb + 1]),  64'd1);
         chk("b_order_id1", 64'(b_log_id[bb + 1]), 64'd5);
      end else chk("b_order_count", 64'(b_log_m.size() - bb), 64'd2);

      // master 1 burst of 4 beats while master 0 toggles junk W
      wb = w_total;
      issue(1, 4'd7, 32'h0000_3000, 8'd3, 4);
      wait_idle(500, "burst4");
      chk("burst4_beats",   64'(w_total - wb), 64'd4);
      chk("burst4_len_err", 64'(len_err), 64'd0);

      // route FIFO full: fifth AW must wait for a B handshake
      b_en = 1'b0;
      ab = aw_done;
      issue(0, 4'd1, 32'h100, 8'd0, 1);
      issue(1, 4'd2, 32'h200, 8'd0, 1);
      issue(0, 4'd3, 32'h300, 8'd0, 1);
      issue(1, 4'd4, 32'h400, 8'd0, 1);
      issue(0, 4'd6, 32'h500, 8'd0, 1);
      repeat (60) @(posedge clk);
      chk("full_aw_accepted", 64'(aw_done - ab), 64'd4);
      b_en = 1'b1;
      wait_idle(1000, "full");
      chk("full_aw_total", 64'(aw_done - ab), 64'd5);

      // randomized traffic
      issue_random(60);
      wait_idle(8000, "random");

      // reset in the middle of an 8-beat burst with a B still outstanding
      b_en = 1'b0;
      issue(1, 4'd9, 32'h600, 8'd0, 1);
      cyc = 0;
      while (aw_done == ab + 5 + 60 + 0 && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      wait_idle_w();
      wb = w_total;
      issue(0, 4'd10, 32'h700, 8'd7, 8);
      cyc = 0;
      while (w_total - wb < 2 && cyc < 400) begin
         @(posedge clk);
         cyc++;
      end
      chk("rst_mid_burst_reached", 64'(w_total - wb >= 2), 64'd1);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      bb = b_log_m.size();
      junk_b = 1'b1;
      repeat (5) @(posedge clk);
      junk_b = 1'b0;
      chk("b_after_rst", 64'(b_log_m.size() - bb), 64'd0);
      chk("state_after_rst", 64'(state_dbg == DATA), 64'd0);
      b_en = 1'b1;
      issue_random(12);
      wait_idle(3000, "post_rst");

`ifdef AXI_WR_ARB_LEN_CHECK_EN
      // awlen=2 but wlast on the second beat
      issue(0, 4'd3, 32'h800, 8'd2, 2);
      wait_idle(500, "len_err");
      @(posedge clk);
      #2 chk("len_err_set", 64'(len_err), 64'd1);
      repeat (10) @(posedge clk);
      #2 chk("len_err_sticky", 64'(len_err), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // waits for the W channel to go quiet after an AW with no B drain (bounded)
   task automatic wait_idle_w();
      for (int c = 0; c < 300; c++) begin
         if (txq[0].size() == 0 && txq[1].size() == 0 &&
             exp_aw_q[0].size() == 0 && exp_aw_q[1].size() == 0 &&
             exp_w_q[0].size() == 0 && exp_w_q[1].size() == 0 && !in_data)
            return;
         @(posedge clk);
      end
      chk("idle_timeout_w", 64'd1, 64'd0);
   endtask

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_wr_rr_arbiter.md
AXI_WR_RR_ARBITER -- requirements
Module: axi_wr_rr_arbiter

Interface
REQ-001 Params: AXI_ID_WIDTH=4 (ID bits); AXI_ADDR_WIDTH=32 (address bits); AXI_DATA_WIDTH=64 (data bits); MAX_OUTSTANDING=4 (B-route depth, power of 2, >=2).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m_awid/m_awaddr/m_awlen  input  [2][ID]/[2][ADDR]/[2][8]  per-master AW payload, index 0 = master 0.
REQ-005 m_awvalid input 2 / m_awready output 2  per-master AW handshake.
REQ-006 m_wdata/m_wlast/m_wvalid  input  [2][DATA]/2/2  per-master W; m_wready  output  2.
REQ-007 m_bid/m_bresp/m_bvalid  output  [2][ID]/[2][2]/2  per-master B; m_bready  input  2.
REQ-008 s_awid/s_awaddr/s_awlen/s_awvalid  output  ID/ADDR/8/1  slave AW; s_awready  input  1.
REQ-009 s_wdata/s_wlast/s_wvalid  output  DATA/1/1  slave W; s_wready  input  1.
REQ-010 s_bid/s_bresp/s_bvalid  input  ID/2/1  slave B; s_bready  output  1.
REQ-011 len_err  output  1  sticky W-beat-count mismatch flag.

Function
REQ-012 FSM states: ARB (AW arbitration) and DATA (W burst forwarding); reset state ARB.
REQ-013 ARB: grant = requesting master when one m_awvalid set; when both set, grant = master not granted last (rr_last), rr_last resets to 1, so master 0 wins first tie.
REQ-014 Once s_awvalid is high without s_awready, grant SHALL be frozen until the handshake; payload stable.
REQ-015 s_aw* driven combinationally from granted master; m_awready[g] = s_awready for granted master only, other master 0.
REQ-016 s_awvalid SHALL be 0 in DATA and whenever B-route FIFO is full (even if a pop occurs same cycle).
REQ-017 AW handshake: record g as w_owner, update rr_last=g, push g into B-route FIFO, load beat counter with awlen, go to DATA next cycle.
REQ-018 DATA: s_w* = m_w*[w_owner]; m_wready[w_owner] = s_wready, other 0; on W handshake with wlast=1 return to ARB next cycle.
REQ-019 W is never forwarded in ARB: s_wvalid=0, m_wready=0.
REQ-020 B routing: head of B-route FIFO selects master; m_bvalid[head]=s_bvalid, m_bid/m_bresp copied, s_bready=m_bready[head]; pop on B handshake.
REQ-021 B-route FIFO empty: s_bready=0, m_bvalid=0 (slave B stalls).
REQ-022 Simultaneous push and pop: occupancy unchanged, both pointers advance, wrap modulo MAX_OUTSTANDING.
REQ-023 Latency: AW and W zero-cycle combinational pass-through; one ARB cycle between wlast handshake and next AW handshake.

Reset
REQ-024 rst asserted (any time, incl. mid-burst): state ARB, rr_last=1, FIFO empty, beat counter 0, len_err 0; all valid/ready outputs 0 while rst high.
REQ-025 Outstanding B responses in flight at reset SHALL be discarded (s_bready=0 after reset until next push).

Configuration
REQ-026 AXI_WR_ARB_LEN_CHECK_EN defined: beat counter decrements per W handshake; wlast at count!=0 or count==0 without wlast sets len_err (sticky until rst); FSM behaviour unchanged.
REQ-027 Macro undefined: no beat counter, len_err tied 0.

Structure
REQ-028 Shared package axi_noc_pkg: parameter defaults, state enum (ARB, DATA), master-index typedef (1 bit).
REQ-029 One sub-module axi_route_fifo: MAX_OUTSTANDING-deep, 1-bit-wide sync FIFO with full/empty, async active-high reset.

Verification
REQ-030 Both masters assert AW after reset -> master 0 granted first, master 1 next; rr_last alternates 0,1.
REQ-031 Master 1 AW awlen=3, 4 W beats, s_wready toggling -> exactly 4 s_w handshakes, wlast on 4th, master 0 W ignored, len_err=0.
REQ-032 4 AWs accepted with s_bvalid held 0 -> 5th AW sees s_awvalid=0 until first B handshake.
REQ-033 B responses bid=2 then bid=5 for owners 0,1 -> delivered to m_bvalid[0] then m_bvalid[1] in order.
REQ-034 rst asserted on beat 2 of awlen=7 burst -> all outputs 0 next cycle, state ARB, FIFO empty.
REQ-035 With AXI_WR_ARB_LEN_CHECK_EN, awlen=2 and wlast on beat 2 -> len_err=1 and stays 1.
